// File: rtl/counter_mon_pkg.sv
// Shared types and constants for the counter monitor and its per-channel
// expected-value models.
package counter_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOAD,
    TRACK,
    FAULT
  } mon_state_t;

  localparam int DEFAULT_WIDTH = 4;

  localparam bit UP   = 1'b1;
  localparam bit DOWN = 1'b0;

endpackage

// File: rtl/counter_monitor_if.sv
// Control and observation signals shared between the up/down counter and the
// monitor that checks it; the monitor only ever listens.
interface counter_monitor_if #(
  parameter int WIDTH = 4
);

  logic             load;
  logic [WIDTH-1:0] data;
  logic             up_down;
  logic             down_up;
  logic [WIDTH-1:0] outu;
  logic [WIDTH-1:0] outd;

  modport master (
    output load,
    output data,
    output up_down,
    output down_up,
    output outu,
    output outd
  );

  modport slave (
    input load,
    input data,
    input up_down,
    input down_up,
    input outu,
    input outd
  );

endinterface

// File: rtl/counter_model.sv
// Expected-value register for one counter channel plus its wrap pulse.
// DIR selects counting up (wrap at max->0) or down (wrap at 0->max).
import counter_mon_pkg::*;

module counter_model #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter bit DIR   = UP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] stepped;
  logic             at_edge;

  always_comb begin
    stepped = (DIR == UP) ? value + WIDTH'(1) : value - WIDTH'(1);
    at_edge = (DIR == UP) ? (value == MAX_VAL) : (value == '0);
  end

  // Load takes priority over counting and never produces a wrap pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (run) begin
        if (load) begin
          value <= data;
        end else if (en) begin
          value <= stepped;
          wrap  <= at_edge;
        end
      end
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Passive checker for the up/down counter: tracks expected values for both
// channels, flags registered mismatches and counts error cycles.
import counter_mon_pkg::*;

module counter_monitor #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ERR_CNT_W = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mon_en,
  counter_monitor_if.slave     bus,
  output logic [WIDTH-1:0]     exp_u,
  output logic [WIDTH-1:0]     exp_d,
  output logic                 mismatch_u,
  output logic                 mismatch_d,
  output logic                 wrap_u,
  output logic                 wrap_d,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 locked,
  output logic                 fault
);

  mon_state_t state, next_state;

  logic                 model_run;
  logic                 cmp_u;
  logic                 cmp_d;
  logic                 any_mis;
  logic                 limit_hit;
  logic [ERR_CNT_W-1:0] err_inc;

  assign model_run = (state != IDLE);

  counter_model #(.WIDTH(WIDTH), .DIR(UP)) u_model_up (
    .clk   (clk),
    .reset (reset),
    .run   (model_run),
    .load  (bus.load),
    .data  (bus.data),
    .en    (bus.up_down),
    .value (exp_u),
    .wrap  (wrap_u)
  );

  counter_model #(.WIDTH(WIDTH), .DIR(DOWN)) u_model_down (
    .clk   (clk),
    .reset (reset),
    .run   (model_run),
    .load  (bus.load),
    .data  (bus.data),
    .en    (bus.down_up),
    .value (exp_d),
    .wrap  (wrap_d)
  );

  // The error counter saturates, so the limit test uses the clamped value.
  always_comb begin
    cmp_u     = (bus.outu != exp_u);
    cmp_d     = (bus.outd != exp_d);
    any_mis   = cmp_u | cmp_d;
    err_inc   = (&err_count) ? err_count : err_count + ERR_CNT_W'(1);
    limit_hit = any_mis && (err_inc == ERR_CNT_W'(ERR_LIMIT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Dropping mon_en always wins, even over a simultaneous load.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mon_en) next_state = WAIT_LOAD;
      end
      WAIT_LOAD, FAULT: begin
        if (!mon_en)       next_state = IDLE;
        else if (bus.load) next_state = TRACK;
      end
      TRACK: begin
        if (!mon_en)        next_state = IDLE;
        else if (limit_hit) next_state = FAULT;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    locked = (state == TRACK);
    fault  = (state == FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch_u <= 1'b0;
      mismatch_d <= 1'b0;
    end else if (state == TRACK) begin
      mismatch_u <= cmp_u;
      mismatch_d <= cmp_d;
    end else begin
      mismatch_u <= 1'b0;
      mismatch_d <= 1'b0;
    end
  end

  // Leaving TRACK through mon_en=0 keeps the count; a new reference clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else begin
      case (state)
        WAIT_LOAD, FAULT: begin
          if (mon_en && bus.load) err_count <= '0;
        end
        TRACK: begin
          if (mon_en && any_mis) err_count <= err_inc;
        end
        default: err_count <= err_count;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_monitor.sv
// Directed self-checking bench for counter_monitor: drives hand-picked counter
// observations and compares every output against hand-computed values.
module tb_counter_monitor;

  localparam int WIDTH     = 4;
  localparam int ERR_CNT_W = 8;
  localparam int ERR_LIMIT = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 mon_en;
  logic [WIDTH-1:0]     exp_u;
  logic [WIDTH-1:0]     exp_d;
  logic                 mismatch_u;
  logic                 mismatch_d;
  logic                 wrap_u;
  logic                 wrap_d;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 locked;
  logic                 fault;

  int checks   = 0;
  int failures = 0;

  counter_monitor_if #(.WIDTH(WIDTH)) bus ();

  counter_monitor #(
    .WIDTH     (WIDTH),
    .ERR_CNT_W (ERR_CNT_W),
    .ERR_LIMIT (ERR_LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mon_en     (mon_en),
    .bus        (bus.slave),
    .exp_u      (exp_u),
    .exp_d      (exp_d),
    .mismatch_u (mismatch_u),
    .mismatch_d (mismatch_d),
    .wrap_u     (wrap_u),
    .wrap_d     (wrap_d),
    .err_count  (err_count),
    .locked     (locked),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic ld, input logic [WIDTH-1:0] d,
                               input logic ud, input logic du,
                               input logic [WIDTH-1:0] ou, input logic [WIDTH-1:0] od);
    mon_en      = en;
    bus.load    = ld;
    bus.data    = d;
    bus.up_down = ud;
    bus.down_up = du;
    bus.outu    = ou;
    bus.outd    = od;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int eu, input int ed, input int mu, input int md,
                          input int wu, input int wd, input int ec, input int lk, input int ft);
    checkOutput({tag, ".exp_u"}, int'(exp_u), eu);
    checkOutput({tag, ".exp_d"}, int'(exp_d), ed);
    checkOutput({tag, ".mismatch_u"}, int'(mismatch_u), mu);
    checkOutput({tag, ".mismatch_d"}, int'(mismatch_d), md);
    checkOutput({tag, ".wrap_u"}, int'(wrap_u), wu);
    checkOutput({tag, ".wrap_d"}, int'(wrap_d), wd);
    checkOutput({tag, ".err_count"}, int'(err_count), ec);
    checkOutput({tag, ".locked"}, int'(locked), lk);
    checkOutput({tag, ".fault"}, int'(fault), ft);
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 reset = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    checkAll("wait_load", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Test 1: load 2 then count up to 15
    applyStimulus(1, 1, 2, 0, 0, 0, 0);
    tick();
    checkAll("t1.load", 2, 2, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 2; i < 15; i++) begin
      applyStimulus(1, 0, 0, 1, 0, WIDTH'(i), 2);
      tick();
      checkOutput("t1.exp_u_step", int'(exp_u), i + 1);
      checkOutput("t1.mismatch_u_step", int'(mismatch_u), 0);
      checkOutput("t1.wrap_u_step", int'(wrap_u), 0);
    end
    checkAll("t1.end", 15, 2, 0, 0, 0, 0, 0, 1, 0);

    // Test 2: wrap 15 -> 0
    applyStimulus(1, 0, 0, 1, 0, 15, 2);
    tick();
    checkAll("t2.wrap", 0, 2, 0, 0, 1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 2);
    tick();
    checkAll("t2.after", 0, 2, 0, 0, 0, 0, 0, 1, 0);

    // Test 3: load wins over down enable, then count down through 0
    applyStimulus(1, 1, 2, 0, 1, 0, 2);
    tick();
    checkAll("t3.load", 2, 2, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 2, 2);
    tick();
    checkAll("t3.d1", 2, 1, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 2, 1);
    tick();
    checkAll("t3.d0", 2, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 2, 0);
    tick();
    checkAll("t3.wrap", 2, 15, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 2, 15);
    tick();
    checkAll("t3.after", 2, 15, 0, 0, 0, 0, 0, 1, 0);

    // Test 4: single mismatch at exp_u=6
    for (int i = 2; i < 6; i++) begin
      applyStimulus(1, 0, 0, 1, 0, WIDTH'(i), 15);
      tick();
    end
    checkAll("t4.at6", 6, 15, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 5, 15);
    tick();
    checkAll("t4.mis", 6, 15, 1, 0, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 6, 15);
    tick();
    checkAll("t4.clear", 6, 15, 0, 0, 0, 0, 1, 1, 0);

    // Leave TRACK (count held), re-enter with a fresh reference (count cleared)
    applyStimulus(0, 0, 0, 0, 0, 6, 15);
    tick();
    checkAll("idle.held", 6, 15, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 6, 15);
    tick();
    checkAll("rearm", 6, 15, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 6, 0, 0, 6, 15);
    tick();
    checkAll("t5.load6", 6, 6, 0, 0, 0, 0, 0, 1, 0);

    // Test 5: three mismatching cycles reach FAULT
    applyStimulus(1, 0, 0, 0, 0, 0, 6);
    tick();
    checkAll("t5.e1", 6, 6, 1, 0, 0, 0, 1, 1, 0);
    tick();
    checkAll("t5.e2", 6, 6, 1, 0, 0, 0, 2, 1, 0);
    tick();
    checkAll("t5.e3", 6, 6, 1, 0, 0, 0, 3, 0, 1);
    tick();
    checkAll("t5.fault_hold", 6, 6, 0, 0, 0, 0, 3, 0, 1);
    applyStimulus(1, 1, 7, 0, 0, 0, 6);
    tick();
    checkAll("t5.reload", 7, 7, 0, 0, 0, 0, 0, 1, 0);

    // Test 6: asynchronous reset between edges
    applyStimulus(1, 0, 0, 1, 0, 7, 7);
    tick();
    checkAll("t6.pre", 8, 7, 0, 0, 0, 0, 0, 1, 0);
    #2 reset = 1'b0;
    #1;
    checkAll("t6.async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 5, 9);
    #2 reset = 1'b1;
    tick();
    checkAll("t6.wait", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkAll("t6.nocmp", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // mon_en=0 together with load: disable wins
    applyStimulus(0, 1, 4, 0, 0, 5, 9);
    tick();
    checkAll("dis_wins", 4, 4, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 5, 9);
    tick();
    checkAll("dis_wins.next", 4, 4, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
Passive receive-side checker for the up/down counter block; it consumes the counter's two output channels and verifies them cycle by cycle.
- Shares the counter's load and enable controls, so it keeps its own expected value for each channel.
- Flags mismatches, counts errors and reports wrap events.
- Sits beside the counter in the design; it is also reused as a bench scoreboard.

Parameters:
WIDTH, 4, counter data width of both channels
ERR_CNT_W, 8, width of error counter (saturating)
ERR_LIMIT, 3, error count at which the monitor enters FAULT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
mon_en  in  1  monitor enable
load  in  1  counter load strobe (same signal driven to counter)
data  in  WIDTH  load value
up_down  in  1  up-channel count enable
down_up  in  1  down-channel count enable
outu  in  WIDTH  observed up-channel counter output
outd  in  WIDTH  observed down-channel counter output
exp_u  out  WIDTH  expected up-channel value for current cycle
exp_d  out  WIDTH  expected down-channel value for current cycle
mismatch_u  out  1  registered: outu != exp_u on previous edge
mismatch_d  out  1  registered: outd != exp_d on previous edge
wrap_u  out  1  one-cycle pulse: exp_u wrapped from max to 0
wrap_d  out  1  one-cycle pulse: exp_d wrapped from 0 to max
err_count  out  ERR_CNT_W  cycles with any mismatch, saturates at all-ones
locked  out  1  high in TRACK
fault  out  1  high in FAULT

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE. Deasserting reset has no effect until the next clk edge.
- Counter model: the counter is registered and updates at the same edge where the monitor samples controls, so the value is visible the cycle after load/enable.
- Next expected value per channel:
  - load → data, regardless of enables (load wins over enable in the same cycle).
  - Else if enabled → up channel +1, down channel −1, modulo 2^WIDTH.
  - Else hold.
- exp_u and exp_d update every edge in WAIT_LOAD, TRACK and FAULT; they hold in IDLE.
- Wrap: wrap_u=1 for exactly one cycle after exp_u goes 2^WIDTH−1 → 0; wrap_d=1 for one cycle after exp_d goes 0 → 2^WIDTH−1. A load never generates a wrap.
- Compare, TRACK only: at each edge, mismatch_u <= (outu != exp_u) and mismatch_d <= (outd != exp_d). Latency is 1 cycle from observation to flag.
- If either channel mismatches, err_count += 1 (one per cycle, not per channel), saturating.
- In all states other than TRACK, mismatch_u and mismatch_d are driven 0.
- FSM:
  - IDLE: mon_en=1 → WAIT_LOAD.
  - WAIT_LOAD: waits for a reference value, no comparisons. load=1 → TRACK; exp takes data; err_count cleared to 0. mon_en=0 → IDLE.
  - TRACK: mon_en=0 → IDLE, with err_count held. On the edge where the incremented err_count reaches ERR_LIMIT → FAULT. A load in TRACK reloads exp but does not clear err_count.
  - FAULT: fault=1, locked=0, no further counting. load=1 → TRACK with err_count cleared. mon_en=0 → IDLE.
- Simultaneous mon_en=0 and load: mon_en=0 wins (→ IDLE).
- Reset mid-operation: immediate return to reset values; the previous expected state is lost.

Decomposition:
- Package counter_mon_pkg:
  - state enum {IDLE, WAIT_LOAD, TRACK, FAULT};
  - default WIDTH constant;
  - UP/DOWN direction constants.
- One sub-module, counter_model:
  - parameters WIDTH and DIR;
  - holds one channel's expected register and wrap pulse;
  - instantiated twice (UP, DOWN).
- FSM, compare and error counter stay in the top module.

Test Plan:
1. Reset low then high, mon_en=1, load=1 with data=2, then up_down=1 for 13 cycles, counter driving outu 2..15 → locked=1, exp_u ends at 15, mismatch_u never 1, err_count=0.
2. Continue 1 more enabled cycle (outu=0) → exp_u=0, wrap_u=1 for exactly one cycle, no mismatch.
3. Load data=2 with down_up=1 asserted same cycle, then 3 enabled cycles, outd 2,1,0,15 → exp_d follows 2,1,0,15 (load wins over enable), wrap_d pulses once at 0→15.
4. In TRACK with exp_u=6, force outu=5 for one cycle → mismatch_u=1 on the next cycle only, err_count=1, locked stays 1.
5. ERR_LIMIT=3: force 3 consecutive mismatching cycles → fault=1, locked=0 after the third edge; then load data=7 → TRACK, err_count=0, exp_u=7.
6. Drive reset=0 asynchronously mid-TRACK (between clk edges) → all outputs 0 immediately; after release with mon_en=1 → WAIT_LOAD, no mismatch until a load occurs.
